// File: rtl/imem_fetch_sequencer.sv
// imem_fetch_sequencer: arbitrates a byte-wide sync instruction memory between 4-byte IF fetches and loader writes
module imem_fetch_sequencer #(
  parameter int ADDR_W = 10
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_flush,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [31:0]       fetch_instr,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              load_ack,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, WRITE} state_t;
  state_t      state;
  logic [1:0]  k;
  logic [23:0] lanes;
  logic        last_load;
  logic        idle, grant_fetch, grant_load;
  assign idle        = state == IDLE;
  // alternate on contention; last_load resets high so fetch wins the first tie
  assign grant_fetch = idle & fetch_req & ~fetch_flush & (~load_req | last_load);
  assign grant_load  = idle & load_req & ~grant_fetch;
  assign fetch_ready = grant_fetch & ~rst;
  assign busy        = ~idle;
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      lanes       <= '0;
      last_load   <= 1'b1;
      fetch_valid <= 1'b0;
      fetch_instr <= '0;
      load_ack    <= 1'b0;
      mem_addr    <= '0;
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
    end else begin
      fetch_valid <= 1'b0;
      load_ack    <= 1'b0;
      case (state)
        IDLE:
          if (grant_fetch) begin
            state     <= FETCH;
            k         <= '0;
            mem_addr  <= fetch_addr;
            mem_re    <= 1'b1;
            last_load <= 1'b0;
          end else if (grant_load) begin
            state     <= WRITE;
            mem_addr  <= load_addr;
            mem_wdata <= load_data;
            mem_we    <= 1'b1;
            load_ack  <= 1'b1;
            last_load <= 1'b1;
          end
        FETCH: begin
          // read data lags the issued address by one beat
          if (k != 2'd0) lanes <= {lanes[15:0], mem_rdata};
          if (fetch_flush) begin
            state  <= IDLE;
            mem_re <= 1'b0;
          end else if (k == 2'd3) begin
            state  <= DRAIN;
            mem_re <= 1'b0;
          end else begin
            k        <= k + 2'd1;
            mem_addr <= mem_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          state <= IDLE;
          if (!fetch_flush) begin
            fetch_valid <= 1'b1;
            fetch_instr <= {lanes, mem_rdata};
          end
        end
        WRITE: begin
          state  <= IDLE;
          mem_we <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// tb_imem_fetch_sequencer: directed and random stimulus against a timeline model of the fetch/load sequencer
module tb_imem_fetch_sequencer;
  logic       clk1 = 1'b0;
  logic       rst;
  logic       fetch_req, fetch_flush, fetch_ready, fetch_valid;
  logic [9:0] fetch_addr, load_addr, mem_addr;
  logic [31:0] fetch_instr;
  logic       load_req, load_ack, busy, mem_re, mem_we;
  logic [7:0] load_data, mem_wdata, mem_rdata = 8'h00;
  imem_fetch_sequencer #(.ADDR_W(10)) dut (
    .clk1(clk1), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_flush(fetch_flush),
    .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data), .load_ack(load_ack),
    .busy(busy), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clk1 = ~clk1;
  logic [7:0] phys [1024];
  logic [7:0] ref_mem [1024];
  always @(posedge clk1) begin
    if (mem_re) mem_rdata <= phys[mem_addr];
    if (mem_we) phys[mem_addr] <= mem_wdata;
  end
  int checks = 0, errors = 0;
  int op = 0, t = 0, n_valid = 0, n_ack = 0;
  logic [9:0] ma = '0, la_m = '0;
  logic [7:0] ld_m = '0;
  logic last_load = 1'b1, last_ack = 1'b0;
  logic [31:0] instr_m = '0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  // one clock cycle: drive, compare against the offset-since-grant timeline, advance the model
  task automatic step(input logic fr, input logic [9:0] fa, input logic ff,
                      input logic lr, input logic [9:0] la, input logic [7:0] ld);
    logic eb, ere, ewe, ev, erdy, gl;
    logic [9:0] eaddr;
    fetch_req = fr; fetch_addr = fa; fetch_flush = ff;
    load_req = lr; load_addr = la; load_data = ld;
    #2;
    eb  = (op == 1 && t >= 1 && t <= 5) || (op == 2 && t == 1);
    ere = op == 1 && t >= 1 && t <= 4;
    ewe = op == 2 && t == 1;
    ev  = op == 1 && t == 6;
    if (ev) instr_m = {ref_mem[ma], ref_mem[ma + 10'd1], ref_mem[ma + 10'd2], ref_mem[ma + 10'd3]};
    eaddr = ere ? ma + 10'(t - 1) : la_m;
    erdy = !eb && fr && !ff && (!lr || last_load);
    gl   = !eb && lr && !erdy;
    chk("busy", busy, eb);
    chk("fetch_ready", fetch_ready, erdy);
    chk("fetch_valid", fetch_valid, ev);
    chk("fetch_instr", fetch_instr, instr_m);
    chk("mem_re", mem_re, ere);
    chk("mem_we", mem_we, ewe);
    chk("load_ack", load_ack, ewe);
    if (ere || ewe) chk("mem_addr", mem_addr, eaddr);
    if (ewe) chk("mem_wdata", mem_wdata, ld_m);
    if (fetch_valid) n_valid++;
    if (load_ack) n_ack++;
    last_ack = ewe;
    if (ewe) ref_mem[la_m] = ld_m;
    if (op == 1 && eb && ff) op = 0;
    if (erdy) begin
      op = 1; t = 1; ma = fa; last_load = 1'b0;
    end else if (gl) begin
      op = 2; t = 1; la_m = la; ld_m = ld; last_load = 1'b1;
    end else if (op != 0 && t < 7) t++;
    @(posedge clk1); #1;
  endtask
  task automatic do_reset();
    fetch_req = 1'b1; fetch_addr = '0; fetch_flush = 1'b0;
    load_req = 1'b1; load_addr = '0; load_data = 8'h00;
    rst = 1'b1;
    #1;
    chk("reset_outputs", {fetch_ready, fetch_valid, fetch_instr, load_ack, busy,
                          mem_addr, mem_re, mem_we, mem_wdata}, 64'd0);
    fetch_req = 1'b0; load_req = 1'b0;
    op = 0; t = 0; last_load = 1'b1; instr_m = '0;
    @(negedge clk1); rst = 1'b0;
    @(posedge clk1); #1;
  endtask
  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask
  logic       lr_r;
  logic [9:0] la_r;
  logic [7:0] ld_r;
  initial begin
    for (int i = 0; i < 1024; i++) begin
      ld_r = 8'($urandom);
      phys[i] = ld_r; ref_mem[i] = ld_r;
    end
    phys[0] = 8'h13; phys[1] = 8'h05; phys[2] = 8'h00; phys[3] = 8'h00;
    phys[10'h3FE] = 8'hAA; phys[10'h3FF] = 8'hBB; phys[10'h010] = 8'h5A;
    for (int i = 0; i < 1024; i++) ref_mem[i] = phys[i];
    do_reset();
    step(1'b1, 10'h000, 1'b0, 1'b0, '0, '0);
    idle_steps(6);
    chk("t1_instr", fetch_instr, 32'h13050000);
    step(1'b1, 10'h3FE, 1'b0, 1'b0, '0, '0);
    idle_steps(6);
    chk("t2_wrap_instr", fetch_instr, 32'hAABB1305);
    step(1'b1, 10'h100, 1'b0, 1'b0, '0, '0);
    idle_steps(2);
    step(1'b0, '0, 1'b1, 1'b0, '0, '0);
    chk("t3_busy_after_flush", busy, 1'b0);
    idle_steps(5);
    chk("t3_instr_kept", fetch_instr, 32'hAABB1305);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 10'h010, 1'b0, 1'b1, 10'h010, 8'hAB);
      if (i == 6) chk("t4_old_byte", fetch_instr[31:24], 8'h5A);
    end
    step(1'b1, 10'h010, 1'b0, 1'b0, '0, '0);
    idle_steps(6);
    chk("t4_new_byte", fetch_instr[31:24], 8'hAB);
    n_valid = 0; n_ack = 0; la_r = 10'h200;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 10'h020, 1'b0, 1'b1, la_r, 8'(la_r));
      if (last_ack) la_r++;
    end
    chk("t5_fetches", n_valid >= 4, 1'b1);
    chk("t5_loads", n_ack >= 4, 1'b1);
    idle_steps(7);
    step(1'b1, 10'h000, 1'b0, 1'b0, '0, '0);
    step(1'b0, '0, 1'b0, 1'b0, '0, '0);
    do_reset();
    step(1'b1, 10'h000, 1'b0, 1'b0, '0, '0);
    idle_steps(6);
    chk("t6_after_reset", fetch_instr, 32'h13050000);
    lr_r = 1'b0; la_r = '0; ld_r = '0;
    for (int i = 0; i < 400; i++) begin
      if (!lr_r && $urandom_range(3) == 0) begin
        lr_r = 1'b1; la_r = 10'($urandom); ld_r = 8'($urandom);
      end
      step($urandom_range(1) == 1, 10'($urandom), $urandom_range(7) == 0, lr_r, la_r, ld_r);
      if (last_ack) lr_r = 1'b0;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
